// File: rtl/clock_divider_arbiter_pkg.sv
// Shared types, widths and helpers for the divider-sharing arbiter.
package clock_divider_arbiter_pkg;

  localparam int unsigned DIV_W      = 32;
  localparam int unsigned MIN_DIV    = 2;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned LANE_IDX_W = 3;
  localparam int unsigned LANES_W    = DIV_W * MAX_REQ;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  // Extract divisor lane idx from a bus padded out to MAX_REQ lanes.
  function automatic logic [DIV_W-1:0] lane_of(input logic [LANES_W-1:0] lanes,
                                               input logic [LANE_IDX_W-1:0] idx);
    logic [DIV_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MAX_REQ); i++) begin
      if (idx == LANE_IDX_W'(i)) r = lanes[i*DIV_W +: DIV_W];
    end
    return r;
  endfunction

  // Divisors below MIN_DIV would let the divider counter overrun on a change.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/clock_divider_arbiter_if.sv
// Requester/divider side bundle of the divider-sharing arbiter.
interface clock_divider_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import clock_divider_arbiter_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [DIV_W*N_REQ-1:0] req_divisor;
  logic                   div_clk;
  logic [DIV_W-1:0]       divisor_out;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       tick;
  logic                   busy;

  modport master (
    output req, req_divisor, div_clk,
    input  divisor_out, grant, tick, busy
  );

  modport slave (
    input  req, req_divisor, div_clk,
    output divisor_out, grant, tick, busy
  );

endinterface

// File: rtl/clock_divider_arbiter_rr_arbiter.sv
// Combinational round-robin pick starting at ptr, skipping excluded requesters.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk candidates ptr, ptr+1, ... mod N; first eligible one wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int k = 0; k < int'(N); k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      cand = sum[IDX_W-1:0];
      for (int j = 0; j < int'(N); j++) begin
        if (!found && (cand == IDX_W'(j)) && req[j] && !excl[j]) begin
          onehot[j] = 1'b1;
          idx       = cand;
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clock_divider_arbiter.sv
// Leases one shared clock divider to N_REQ requesters round-robin and
// returns a per-owner tick on each divider rising edge.
module clock_divider_arbiter
  import clock_divider_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned LEASE    = 16,
  parameter int unsigned PARK_DIV = 2
) (
  input  logic                    basys_clk,
  input  logic                    reset,
  clock_divider_arbiter_if.slave  bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = (LEASE > 0) ? $clog2(LEASE + 1) : 1;

  // Registered state
  logic             div_q;
  state_t           state;
  logic [IDX_W-1:0] last_owner;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] grant_q;
  logic [DIV_W-1:0] divisor_q;
  logic [N_REQ-1:0] tick_q;
  logic             busy_q;

  // Next-state values
  state_t           d_state;
  logic [IDX_W-1:0] d_last;
  logic [CNT_W-1:0] d_cnt;
  logic [N_REQ-1:0] d_grant;
  logic [DIV_W-1:0] d_div;
  logic [N_REQ-1:0] d_tick;
  logic             d_busy;

  logic             div_rise;
  logic             div_edge;
  logic             owner_req;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [LANES_W-1:0] lanes_all;
  logic [DIV_W-1:0] win_div;

  assign div_rise  = bus.div_clk & ~div_q;
  assign div_edge  = bus.div_clk ^ div_q;
  // grant_q is onehot(owner) in RUN and zero in IDLE.
  assign owner_req = |(bus.req & grant_q);
  assign ptr       = (last_owner == IDX_W'(N_REQ - 1)) ? '0 : last_owner + IDX_W'(1);
  assign win_valid = |win_onehot;
  assign lanes_all = LANES_W'(bus.req_divisor);
  assign win_div   = clamp_div(lane_of(lanes_all, LANE_IDX_W'(win_idx)));

  // Owner is excluded so a handover never re-picks the current lease holder.
  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (bus.req),
    .ptr    (ptr),
    .excl   (grant_q),
    .onehot (win_onehot),
    .idx    (win_idx)
  );

  // Next-state and output decode; decisions only on div_clk edges.
  always_comb begin
    d_state = state;
    d_last  = last_owner;
    d_cnt   = cnt;
    d_grant = grant_q;
    d_div   = divisor_q;
    d_tick  = grant_q & {N_REQ{div_rise}};

    case (state)
      IDLE: begin
        if (div_edge && win_valid) begin
          d_state = RUN;
          d_grant = win_onehot;
          d_div   = win_div;
          d_cnt   = '0;
          d_last  = win_idx;
        end
      end
      RUN: begin
        if (div_rise && (cnt < CNT_W'(LEASE))) d_cnt = cnt + CNT_W'(1);
        if (div_edge) begin
          if (!owner_req) begin
            d_state = IDLE;
            d_grant = '0;
            d_div   = DIV_W'(PARK_DIV);
          end else if ((cnt >= CNT_W'(LEASE)) && win_valid) begin
            d_grant = win_onehot;
            d_div   = win_div;
            d_cnt   = '0;
            d_last  = win_idx;
          end
        end
      end
      default: begin
        d_state = IDLE;
        d_grant = '0;
        d_div   = DIV_W'(PARK_DIV);
      end
    endcase

    d_busy = |d_grant;
  end

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      div_q      <= 1'b0;
      state      <= IDLE;
      last_owner <= IDX_W'(N_REQ - 1);
      cnt        <= '0;
      grant_q    <= '0;
      divisor_q  <= DIV_W'(PARK_DIV);
      tick_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      div_q      <= bus.div_clk;
      state      <= d_state;
      last_owner <= d_last;
      cnt        <= d_cnt;
      grant_q    <= d_grant;
      divisor_q  <= d_div;
      tick_q     <= d_tick;
      busy_q     <= d_busy;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.divisor_out = divisor_q;
  assign bus.tick        = tick_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/clock_divider_arbiter.md
# clock_divider_arbiter

Shares the single programmable clock divider between up to `N_REQ` requesters: time-multiplexes the divider's 32-bit divisor, grants it round-robin in leases of `LEASE` output periods, and returns a one-cycle tick per divider rising edge to the current owner. Sits between the divider, which takes `divisor_out` and returns `div_clk`, and consumers such as the animation timer, cursor blink and buzzer, so no extra divider instances are needed. Divisor changes happen only just after a `div_clk` edge, so the free-running divider counter never overruns a smaller new divisor.

## Interface
- `N_REQ`, 4: number of requesters, 1..8.
- `LEASE`, 16: `div_clk` rising edges per lease before handover to a waiting requester.
- `PARK_DIV`, 2: divisor driven while no grant exists. Must be ≥2.
- `basys_clk` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in N_REQ: level request, one bit per requester.
- `req_divisor` in 32*N_REQ: requested divisor. Lane i is bits [32i+31:32i].
- `div_clk` in 1: divider output, synchronous to `basys_clk`.
- `divisor_out` out 32: to the divider. Reset value `PARK_DIV`.
- `grant` out N_REQ: one-hot or zero. Reset value 0.
- `tick` out N_REQ: one-cycle pulse per owner period. Reset value 0.
- `busy` out 1: equals |grant. Reset value 0.

## Operation
- Edge detect:
  - `div_q` is `div_clk` registered. Reset value 0.
  - `rise = div_clk & ~div_q`.
  - `edge = div_clk ^ div_q`.
- Clamp: the effective divisor is `max(req_divisor[i], 2)`.
- States:
  - IDLE: `grant`=0, `divisor_out`=`PARK_DIV`.
  - RUN: `grant`=onehot(owner), `divisor_out`=clamp(owner lane).
- IDLE → RUN: on the cycle with `edge` and any `req`. The winner is picked round-robin, starting at `last_owner+1` mod N_REQ.
- In the same register update:
  - `grant` and `divisor_out` load.
  - Lease counter `cnt` is set to 0.
  - `last_owner` is set to the winner.
- RUN, each `rise`: `cnt` increments, saturating at `LEASE`.
- RUN decisions are evaluated only on `edge` cycles, in this priority order:
  1. `req[owner]`=0 → IDLE. `grant` goes to 0 and `divisor_out` goes to `PARK_DIV`.
  2. `cnt`≥LEASE and another `req` is set → direct handover to the round-robin winner, excluding the owner. `cnt` goes to 0 and the state stays RUN.
  3. Otherwise stay. This includes a lease expiring with no contender, where the lease renews and `cnt` holds at `LEASE`.
- `req_divisor[owner]` changes while in RUN are not applied. A new value takes effect only on the next grant.
- `tick` register is `grant & {N_REQ{rise}}`, using the pre-update `grant`. The edge that causes a handover therefore ticks the old owner.
- Reset mid-lease: every register returns to its reset value on the next clock. `last_owner` resets to N_REQ-1, so requester 0 wins first.

## Timing
- Request to grant latency: from `req` high to `grant` high is at most 2·`PARK_DIV`+2 cycles while idle. Contended requests wait for the owner's lease plus one `div_clk` half-period.
- `tick` is high exactly one cycle, the cycle after `rise` is seen. It never overlaps a requester without grant in the previous cycle.
- Release: the owner dropping `req` releases the grant at the next `edge`, up to one half-period of the old divisor.
- `divisor_out` changes only on the clock following an `edge` cycle. The divider counter is then ≤2, so clamped divisors ≥2 never wrap.
- Simultaneous requests: round-robin order resolves them. A requester that rises in the same cycle as the owner's release competes in that same decision.

## Structure
- Shared package holds:
  - The state enum (IDLE, RUN).
  - `DIV_W`=32.
  - `MIN_DIV`=2.
  - The lane-slicing helper.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs are the request vector, the pointer and an exclude mask. Outputs are a one-hot result and an index.
- This block holds the FSM, counters and edge detect. The divider stays outside.

## Test plan
- Reset while in RUN with `grant`=0010 → next cycle `grant`=0, `divisor_out`=2, `tick`=0, `busy`=0.
- `req`=0001, lane0=10, divider model attached → `grant`=0001 within 6 cycles, then `tick[0]` every 22 cycles, and `divisor_out`=10.
- `req`=0011, lane0=4, lane1=6, `LEASE`=16 → 16 `tick[0]` pulses, handover to 0010 at the next edge, 16 `tick[1]` pulses, then back to 0001.
- Lane2=0 requested alone → `divisor_out`=2, and `tick[2]` period is 6 cycles.
- Owner 0 with divisor 1000 drops `req` mid-lease → grant released within 1001 cycles, `divisor_out`=2, no further `tick[0]`.
- Sole requester `req`=0100 held for 40 periods → lease renews, grant never drops, and 40 ticks are counted.
